// File: rtl/gray_fifo_ctrl.sv
// gray_fifo_ctrl
//   Single-clock FIFO pointer controller for a 2^PTR-entry dual-port RAM.
//   Keeps binary and Gray read/write pointers (PTR+1 bits, MSB = wrap bit).
//   It generates RAM enables and addresses, full/empty/level status and
//   sticky overflow/underflow flags. The registered Gray pointers are
//   exported so that a domain-crossing stage can sample them.
//
// Parameters
//   PTR        address width (2..10), depth = 2^PTR
//   AF_THRESH  almost_full threshold  (GRAY_FIFO_ALMOST_EN only)
//   AE_THRESH  almost_empty threshold (GRAY_FIFO_ALMOST_EN only)
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   flush              synchronous flush: read pointer jumps to write pointer
//   wr_en, rd_en       write / read requests
//   mem_we, mem_re     RAM enables (accepted write / read, same cycle)
//   wr_addr, rd_addr   RAM addresses (low PTR bits of binary pointers)
//   full, empty, level registered status, level in 0..2^PTR
//   wr_ptr_gray        registered Gray write pointer
//   rd_ptr_gray        registered Gray read pointer
//   overflow           sticky: write attempted while full
//   underflow          sticky: read attempted while empty
//   almost_full        level >= AF_THRESH   (GRAY_FIFO_ALMOST_EN only)
//   almost_empty       level <= AE_THRESH   (GRAY_FIFO_ALMOST_EN only)
//
// Build option
//   GRAY_FIFO_ALMOST_EN  adds the almost_full / almost_empty outputs.

module gray_fifo_ctrl #(
  parameter int PTR       = 4,
  parameter int AF_THRESH = (1 << PTR) - 2,
  parameter int AE_THRESH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           wr_en,
  input  logic           rd_en,
  output logic           mem_we,
  output logic           mem_re,
  output logic [PTR-1:0] wr_addr,
  output logic [PTR-1:0] rd_addr,
  output logic           full,
  output logic           empty,
  output logic [PTR:0]   level,
  output logic [PTR:0]   wr_ptr_gray,
  output logic [PTR:0]   rd_ptr_gray,
  output logic           overflow,
  output logic           underflow
`ifdef GRAY_FIFO_ALMOST_EN
  ,
  output logic           almost_full,
  output logic           almost_empty
`endif
);

  logic [PTR:0] wr_bin;
  logic [PTR:0] rd_bin;
  logic [PTR:0] wr_bin_next;
  logic [PTR:0] rd_bin_next;
  logic [PTR:0] wr_gray_next;
  logic [PTR:0] rd_gray_next;
  logic [PTR:0] level_next;
  logic         full_next;
  logic         empty_next;
  logic         wr_acc;
  logic         rd_acc;

  assign wr_acc  = wr_en & ~full  & ~flush;
  assign rd_acc  = rd_en & ~empty & ~flush;
  assign mem_we  = wr_acc;
  assign mem_re  = rd_acc;
  assign wr_addr = wr_bin[PTR-1:0];
  assign rd_addr = rd_bin[PTR-1:0];

  // Status is derived from next-state pointers so that it is registered on
  // the same edge as the pointers and never lags them.
  always_comb begin
    wr_bin_next  = wr_bin + {{PTR{1'b0}}, wr_acc};
    rd_bin_next  = flush ? wr_bin : (rd_bin + {{PTR{1'b0}}, rd_acc});
    wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);
    rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);
    empty_next   = (wr_gray_next == rd_gray_next);
    // Full: the two Gray MSBs differ and the rest match.
    full_next    = (wr_gray_next == {~rd_gray_next[PTR:PTR-1], rd_gray_next[PTR-2:0]});
    level_next   = wr_bin_next - rd_bin_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bin      <= '0;
      rd_bin      <= '0;
      wr_ptr_gray <= '0;
      rd_ptr_gray <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      level       <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      wr_bin      <= wr_bin_next;
      rd_bin      <= rd_bin_next;
      wr_ptr_gray <= wr_gray_next;
      rd_ptr_gray <= rd_gray_next;
      full        <= full_next;
      empty       <= empty_next;
      level       <= level_next;
      overflow    <= overflow  | (wr_en & full  & ~flush);
      underflow   <= underflow | (rd_en & empty & ~flush);
    end
  end

`ifdef GRAY_FIFO_ALMOST_EN
  localparam logic [PTR:0] AF_LVL = (PTR+1)'(AF_THRESH);
  localparam logic [PTR:0] AE_LVL = (PTR+1)'(AE_THRESH);

  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (level_next >= AF_LVL);
      almost_empty <= (level_next <= AE_LVL);
    end
  end
`else
  // Thresholds only matter with the almost flags; this elaboration-time
  // check keeps them referenced without generating any hardware.
  if ((AF_THRESH > (1 << PTR)) || (AE_THRESH > (1 << PTR))) begin : g_thresh_out_of_range
  end
`endif

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// tb_gray_fifo_ctrl
//   Directed self-checking bench for gray_fifo_ctrl with PTR=4.
//   The almost_full / almost_empty checks are included when
//   GRAY_FIFO_ALMOST_EN is defined.

module tb_gray_fifo_ctrl;

  localparam int PTR = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           wr_en;
  logic           rd_en;
  logic           mem_we;
  logic           mem_re;
  logic [PTR-1:0] wr_addr;
  logic [PTR-1:0] rd_addr;
  logic           full;
  logic           empty;
  logic [PTR:0]   level;
  logic [PTR:0]   wr_ptr_gray;
  logic [PTR:0]   rd_ptr_gray;
  logic           overflow;
  logic           underflow;
`ifdef GRAY_FIFO_ALMOST_EN
  logic           almost_full;
  logic           almost_empty;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  gray_fifo_ctrl #(.PTR(PTR)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .overflow    (overflow),
    .underflow   (underflow)
`ifdef GRAY_FIFO_ALMOST_EN
    ,
    .almost_full (almost_full),
    .almost_empty(almost_empty)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Apply inputs, then let combinational outputs settle before the next edge.
  task automatic drive(input logic w, input logic r, input logic f);
    wr_en = w;
    rd_en = r;
    flush = f;
    #1;
  endtask

  // Clock edge, then sample registered outputs 1ns later with inputs idle.
  task automatic tick();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    tick();
  endtask

  function automatic logic [PTR:0] g2b(input logic [PTR:0] g);
    logic [PTR:0] b;
    b[PTR] = g[PTR];
    for (int i = PTR - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  initial begin
    logic [PTR:0] prev_gray;
    int unsigned  wcnt;

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Reset state
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_wgray", wr_ptr_gray, 0);
    check("rst_rgray", rd_ptr_gray, 0);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);

    // Fill with 16 writes
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      check("fill_we", mem_we, 1);
      check("fill_waddr", wr_addr, i);
      tick();
      check("fill_level", level, i + 1);
      check("fill_full", full, (i == 15) ? 1 : 0);
      check("fill_empty", empty, 0);
    end
    check("full_wgray", wr_ptr_gray, 5'b11000);
    check("full_rgray", rd_ptr_gray, 0);

    // 17th write is rejected
    drive(1'b1, 1'b0, 1'b0);
    check("ovf_we", mem_we, 0);
    tick();
    check("ovf_flag", overflow, 1);
    check("ovf_level", level, 16);
    check("ovf_wgray", wr_ptr_gray, 5'b11000);

    // Read + write while full: only read taken
    drive(1'b1, 1'b1, 1'b0);
    check("rwfull_re", mem_re, 1);
    check("rwfull_we", mem_we, 0);
    check("rwfull_raddr", rd_addr, 0);
    tick();
    check("rwfull_level", level, 15);
    check("rwfull_full", full, 0);
    check("rwfull_ovf", overflow, 1);
    check("rwfull_rgray", rd_ptr_gray, 5'b00001);

    // Underflow from empty, then read + write while empty
    do_reset();
    check("rst2_ovf", overflow, 0);
    drive(1'b0, 1'b1, 1'b0);
    check("udf_re", mem_re, 0);
    tick();
    check("udf_flag", underflow, 1);
    check("udf_empty", empty, 1);
    drive(1'b1, 1'b1, 1'b0);
    check("rwempty_we", mem_we, 1);
    check("rwempty_re", mem_re, 0);
    tick();
    check("rwempty_level", level, 1);
    check("rwempty_empty", empty, 0);

    // Stream 40 writes / 40 reads, pointers wrap past 2^(PTR+1)
    do_reset();
    wcnt = 0;
    prev_gray = wr_ptr_gray;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      check("strm_we", mem_we, 1);
      tick();
      wcnt++;
      check("strm_wstep", $countones(prev_gray ^ wr_ptr_gray), 1);
      check("strm_g2b_w", g2b(wr_ptr_gray), wcnt % 32);
      check("strm_lvl1", level, 1);
      prev_gray = wr_ptr_gray;
      drive(1'b0, 1'b1, 1'b0);
      check("strm_re", mem_re, 1);
      tick();
      check("strm_rhold", $countones(prev_gray ^ wr_ptr_gray), 0);
      check("strm_g2b_r", g2b(rd_ptr_gray), wcnt % 32);
      check("strm_empty", empty, 1);
    end
    check("strm_end_level", level, 0);
    check("strm_end_wgray", wr_ptr_gray, 5'b01100);
    check("strm_end_udf", underflow, 0);

    // Flush at level 9 with a write pending; sticky underflow retained
    do_reset();
    drive(1'b0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      tick();
    end
    check("pre_flush_level", level, 9);
    drive(1'b1, 1'b1, 1'b1);
    check("flush_we", mem_we, 0);
    check("flush_re", mem_re, 0);
    tick();
    check("flush_empty", empty, 1);
    check("flush_level", level, 0);
    check("flush_full", full, 0);
    check("flush_wgray", wr_ptr_gray, 5'b01101);
    check("flush_rgray", rd_ptr_gray, 5'b01101);
    check("flush_addr", rd_addr, 9);
    check("flush_udf", underflow, 1);
    check("flush_ovf", overflow, 0);

`ifdef GRAY_FIFO_ALMOST_EN
    do_reset();
    check("ae_rst", almost_empty, 1);
    check("af_rst", almost_full, 0);
    for (int i = 1; i <= 14; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      tick();
      check("ae_lvl", almost_empty, (i <= 2) ? 1 : 0);
      check("af_lvl", almost_full, (i >= 14) ? 1 : 0);
    end
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    tick();
    check("ae_midrst", almost_empty, 1);
    check("af_midrst", almost_full, 0);
    check("midrst_wgray", wr_ptr_gray, 0);
    check("midrst_waddr", wr_addr, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
